// File: rtl/imem_loader.sv
// imem_loader: byte-stream instruction-memory writer for simple_core.
//
// The stream begins with a 16-bit little-endian length, counted in words.
// The data bytes follow. Bytes are packed little-endian into DATA_WIDTH-bit
// words, and the words are written to instruction memory starting at
// address 0. The core is held in reset until a complete, legal image has
// been loaded.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   When defined, one trailing byte follows the data. This byte must equal
//   the XOR of all data bytes. A match enters DONE; a mismatch enters ERROR.
//   When undefined, the last data word goes straight to DONE.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start_i           restart pulse; honoured in DONE/ERROR only
//   byte_i            stream byte
//   byte_valid_i      stream valid
//   byte_ready_o      stream ready
//   imem_we_o         one-cycle write strobe per word
//   imem_addr_o       word address of the write
//   imem_wdata_o      word data of the write
//   core_n_reset_o    active-low core reset; high only in DONE
//   load_done_o       high in DONE
//   error_o           high in ERROR
module imem_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [7:0]            byte_i,
    input  logic                  byte_valid_i,
    output logic                  byte_ready_o,
    output logic                  imem_we_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    output logic [DATA_WIDTH-1:0] imem_wdata_o,
    output logic                  core_n_reset_o,
    output logic                  load_done_o,
    output logic                  error_o
);

    localparam int BPW = DATA_WIDTH / 8;
    localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [BCW-1:0] LAST_LANE = BCW'(BPW - 1);
    localparam logic [31:0]    DEPTH     = 32'd1 << ADDR_WIDTH;

    // CHECK is only reachable when the checksum feature is built in.
    typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR} state_t;

    state_t                state;
    logic [7:0]            len_lo;
    logic [15:0]           len;
    logic [ADDR_WIDTH:0]   word_cnt;   // one extra bit so len == depth is legal
    logic [BCW-1:0]        byte_cnt;
    logic [DATA_WIDTH-1:0] wbuf;
    logic [DATA_WIDTH-1:0] next_word;
    logic [7:0]            csum;
    logic [15:0]           len_full;
    logic                  xfer;
    logic                  last_word;

    assign byte_ready_o = (state != DONE) && (state != ERROR);
    assign xfer         = byte_valid_i && byte_ready_o;
    assign len_full     = {byte_i, len_lo};
    assign last_word    = (32'(word_cnt) + 32'd1) == 32'(len);

    // Partial word with the incoming byte dropped into its lane.
    always_comb begin
        next_word = wbuf;
        next_word[int'(byte_cnt)*8 +: 8] = byte_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= LEN_LO;
            len_lo         <= '0;
            len            <= '0;
            word_cnt       <= '0;
            byte_cnt       <= '0;
            wbuf           <= '0;
            csum           <= '0;
            imem_we_o      <= 1'b0;
            imem_addr_o    <= '0;
            imem_wdata_o   <= '0;
            core_n_reset_o <= 1'b0;
            load_done_o    <= 1'b0;
            error_o        <= 1'b0;
        end else begin
            imem_we_o <= 1'b0;
            unique case (state)
                LEN_LO: begin
                    if (xfer) begin
                        len_lo <= byte_i;
                        state  <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        len      <= len_full;
                        word_cnt <= '0;
                        byte_cnt <= '0;
                        csum     <= '0;
                        if (32'(len_full) > DEPTH) begin
                            state   <= ERROR;
                            error_o <= 1'b1;
                        end else if (len_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state <= CHECK;
`else
                            state          <= DONE;
                            core_n_reset_o <= 1'b1;
                            load_done_o    <= 1'b1;
`endif
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        csum <= csum ^ byte_i;
                        if (byte_cnt == LAST_LANE) begin
                            byte_cnt     <= '0;
                            wbuf         <= next_word;
                            imem_we_o    <= 1'b1;
                            imem_addr_o  <= word_cnt[ADDR_WIDTH-1:0];
                            imem_wdata_o <= next_word;
                            word_cnt     <= word_cnt + 1'b1;
                            if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state <= CHECK;
`else
                                state          <= DONE;
                                core_n_reset_o <= 1'b1;
                                load_done_o    <= 1'b1;
`endif
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                            wbuf     <= next_word;
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (xfer) begin
                        if (byte_i == csum) begin
                            state          <= DONE;
                            core_n_reset_o <= 1'b1;
                            load_done_o    <= 1'b1;
                        end else begin
                            // Words already written stay in memory; the core stays in reset.
                            state   <= ERROR;
                            error_o <= 1'b1;
                        end
                    end
                end
`endif
                DONE: begin
                    if (start_i) begin
                        state          <= LEN_LO;
                        core_n_reset_o <= 1'b0;
                        load_done_o    <= 1'b0;
                    end
                end
                ERROR: begin
                    if (start_i) begin
                        state   <= LEN_LO;
                        error_o <= 1'b0;
                    end
                end
                default: state <= LEN_LO;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int AW = 8;
    localparam int DW = 32;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start_i;
    logic [7:0]    byte_i;
    logic          byte_valid_i;
    logic          byte_ready_o;
    logic          imem_we_o;
    logic [AW-1:0] imem_addr_o;
    logic [DW-1:0] imem_wdata_o;
    logic          core_n_reset_o;
    logic          load_done_o;
    logic          error_o;

    imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .start_i(start_i),
        .byte_i(byte_i), .byte_valid_i(byte_valid_i), .byte_ready_o(byte_ready_o),
        .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o), .imem_wdata_o(imem_wdata_o),
        .core_n_reset_o(core_n_reset_o), .load_done_o(load_done_o), .error_o(error_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           exp_q[$];
    logic [DW-1:0] img_q[$];
    int            checks = 0;
    int            errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe cycle must match the next expected write.
    always begin
        @(posedge clk);
        #1;
        if (imem_we_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {56'd0, imem_addr_o}, 64'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", {56'd0, imem_addr_o}, {56'd0, e.addr});
                check("wr_data", {32'd0, imem_wdata_o}, {32'd0, e.data});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit toggle);
        byte_i       = b;
        byte_valid_i = 1'b1;
        check("ready_during_load", {63'd0, byte_ready_o}, 64'd1);
        tick();
        if (toggle) begin
            byte_valid_i = 1'b0;
            tick();
        end
    endtask

    // Sends the header and nw words from img_q; expected writes are queued
    // as the final byte of each word is driven.
    task automatic load_img(input logic [15:0] len, input int nw, input bit toggle,
                            input bit csum_en);
        logic [7:0] cs;
        logic [7:0] bt;
        cs = 8'h00;
        send(len[7:0], toggle);
        send(len[15:8], toggle);
        for (int w = 0; w < nw; w++) begin
            for (int b = 0; b < DW/8; b++) begin
                bt = img_q[w][8*b +: 8];
                cs = cs ^ bt;
                if (b == DW/8 - 1) exp_q.push_back('{AW'(w), img_q[w]});
                send(bt, toggle);
            end
        end
        if (csum_en && CSUM) send(cs, toggle);
        byte_valid_i = 1'b0;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 40 && load_done_o !== 1'b1; i++) tick();
        check(tag, {63'd0, load_done_o}, 64'd1);
        check({tag, "_core_rst"}, {63'd0, core_n_reset_o}, 64'd1);
        check({tag, "_ready"}, {63'd0, byte_ready_o}, 64'd0);
        check({tag, "_err"}, {63'd0, error_o}, 64'd0);
    endtask

    task automatic wait_err(input string tag);
        for (int i = 0; i < 40 && error_o !== 1'b1; i++) tick();
        check(tag, {63'd0, error_o}, 64'd1);
        check({tag, "_ready"}, {63'd0, byte_ready_o}, 64'd0);
        check({tag, "_core_rst"}, {63'd0, core_n_reset_o}, 64'd0);
        check({tag, "_done"}, {63'd0, load_done_o}, 64'd0);
    endtask

    task automatic drain(input string tag);
        tick();
        tick();
        check(tag, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, {63'd0, byte_ready_o}, 64'd1);
        check({tag, "_we"}, {63'd0, imem_we_o}, 64'd0);
        check({tag, "_addr"}, {56'd0, imem_addr_o}, 64'd0);
        check({tag, "_wdata"}, {32'd0, imem_wdata_o}, 64'd0);
        check({tag, "_core_rst"}, {63'd0, core_n_reset_o}, 64'd0);
        check({tag, "_done"}, {63'd0, load_done_o}, 64'd0);
        check({tag, "_err"}, {63'd0, error_o}, 64'd0);
    endtask

    initial begin
        reset = 1'b1; start_i = 1'b0; byte_i = 8'h00; byte_valid_i = 1'b0;
        tick(); tick();
        check_reset_vals("rst_held");
        reset = 1'b0;
        tick();
        check_reset_vals("rst_released");

        // 1: two-word image, valid held high.
        img_q = '{32'h1234_5678, 32'hDEAD_BEEF};
        load_img(16'd2, 2, 1'b0, 1'b1);
        wait_done("t1_done");
        drain("t1_writes");
        // Bytes offered in DONE are not consumed and cause nothing.
        byte_valid_i = 1'b1; byte_i = 8'h55;
        tick(); tick();
        byte_valid_i = 1'b0;
        check("t1_done_holds", {63'd0, load_done_o}, 64'd1);
        drain("t1_no_extra_writes");

        // 2: same image, valid toggling.
        pulse_start();
        check("t2_restart_core_rst", {63'd0, core_n_reset_o}, 64'd0);
        check("t2_restart_done", {63'd0, load_done_o}, 64'd0);
        check("t2_restart_ready", {63'd0, byte_ready_o}, 64'd1);
        load_img(16'd2, 2, 1'b1, 1'b1);
        wait_done("t2_done");
        drain("t2_writes");

        // 3: oversize length goes to ERROR with no writes.
        pulse_start();
        send(8'h01, 1'b0);
        send(8'h01, 1'b0);
        byte_valid_i = 1'b1; byte_i = 8'hAA;
        wait_err("t3_err");
        pulse_start();  // start is ignored nowhere here: ERROR honours it
        byte_valid_i = 1'b0;
        check("t3_err_cleared", {63'd0, error_o}, 64'd0);
        check("t3_ready_back", {63'd0, byte_ready_o}, 64'd1);
        drain("t3_no_writes");

        // 4: full 256-word image, then a 1-word reload.
        img_q.delete();
        for (int w = 0; w < 256; w++) img_q.push_back((32'(w) * 32'h0101_0101) ^ 32'hA55A_0FF0);
        load_img(16'd256, 256, 1'b0, 1'b1);
        wait_done("t4_done");
        check("t4_last_addr", {56'd0, imem_addr_o}, 64'hFF);
        drain("t4_writes");
        pulse_start();
        check("t4_reload_core_rst", {63'd0, core_n_reset_o}, 64'd0);
        img_q = '{32'h0BAD_F00D};
        load_img(16'd1, 1, 1'b0, 1'b1);
        wait_done("t4_reload_done");
        drain("t4_reload_writes");

        // Zero-length image goes straight to DONE without writes.
        pulse_start();
        load_img(16'd0, 0, 1'b0, 1'b1);
        wait_done("t4_len0_done");
        drain("t4_len0_no_writes");

        // 5: reset after 6 data bytes (one word written, one partial).
        pulse_start();
        img_q = '{32'h1111_2222, 32'h3333_4444};
        send(8'h02, 1'b0);
        send(8'h00, 1'b0);
        for (int b = 0; b < 4; b++) begin
            if (b == 3) exp_q.push_back('{AW'(0), img_q[0]});
            send(img_q[0][8*b +: 8], 1'b0);
        end
        send(8'h44, 1'b0);
        send(8'h44, 1'b0);
        byte_valid_i = 1'b0;
        drain("t5_first_word");
        reset = 1'b1;
        tick();
        check_reset_vals("t5_rst");
        reset = 1'b0;
        tick();
        img_q = '{32'hD4C3_B2A1};
        load_img(16'd1, 1, 1'b0, 1'b1);
        wait_done("t5_fresh_done");
        drain("t5_fresh_writes");

        if (CSUM) begin
            // 6: correct checksum (XOR of data bytes) then a wrong one.
            pulse_start();
            img_q = '{32'h1234_5678, 32'hDEAD_BEEF};
            load_img(16'd2, 2, 1'b0, 1'b1);
            wait_done("t6_csum_ok");
            drain("t6_ok_writes");
            pulse_start();
            load_img(16'd2, 2, 1'b0, 1'b0);
            send(8'h00, 1'b0);
            byte_valid_i = 1'b0;
            wait_err("t6_csum_bad");
            drain("t6_bad_writes_kept");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
